// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encodings, default baud divisor,
// default byte width and an elaboration-time clog2 helper.
package uart_pkg;

    typedef enum logic [1:0] {
        UART_ARB_IDLE      = 2'd0,
        UART_ARB_ISSUE     = 2'd1,
        UART_ARB_WAIT_DONE = 2'd2,
        UART_ARB_RELEASE   = 2'd3
    } uart_arb_state_t;

    // Clock cycles per bit for 50 MHz at 9600 baud
    localparam int CLKS_PER_BIT = 5208;

    // Default byte width of the UART data path
    localparam int UART_DATA_WIDTH = 8;

    // Ceiling log2, never smaller than 1 so a single-entry index still has a bit
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority picker: the requester right after last_grant
// has the highest priority, last_grant itself the lowest.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]        req,
    input  logic [clog2(NUM_REQ)-1:0] last_grant,
    output logic                      found,
    output logic [clog2(NUM_REQ)-1:0] winner
);

    localparam int IDX_W = clog2(NUM_REQ);

    // cand_idx[k] is the requester examined at priority rank k (0 = highest)
    logic [IDX_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_req;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand_idx[gi] = IDX_W'((int'(last_grant) + gi + 1) % NUM_REQ);
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Pick the lowest-ranked active candidate; scanning downwards lets rank 0 win
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                found  = 1'b1;
                winner = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte-stream requesters.
// Round-robin with packet lock: a grant is held until the last byte of a
// packet, the requester goes quiet, or MAX_BURST bytes were sent. A watchdog
// abandons a grant whose serializer never reports completion.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = UART_DATA_WIDTH,
    parameter int MAX_BURST      = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          tx_start,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_busy,
    input  logic                          tx_done,
    output logic [clog2(NUM_REQ)-1:0]     grant_id,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int IDX_W   = clog2(NUM_REQ);
    localparam int BURST_W = clog2(MAX_BURST + 1);
    localparam int WDOG_W  = clog2(TIMEOUT_CYCLES);

    localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_BURST);
    localparam logic [WDOG_W-1:0]  WDOG_LIMIT  = WDOG_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]   LAST_INIT   = IDX_W'(NUM_REQ - 1);

    uart_arb_state_t state_reg;
    uart_arb_state_t state_next;

    logic [IDX_W-1:0]      grant_reg;
    logic [IDX_W-1:0]      last_grant_reg;
    logic [BURST_W-1:0]    burst_cnt_reg;
    logic [WDOG_W-1:0]     wdog_reg;
    logic                  last_flag_reg;
    logic [DATA_WIDTH-1:0] tx_data_reg;
    logic                  timeout_err_reg;

    logic                  arb_found;
    logic [IDX_W-1:0]      arb_winner;
    logic                  grant_req;
    logic                  grant_last;
    logic [DATA_WIDTH-1:0] grant_data;
    logic                  issue_fire;
    logic                  wdog_expired;
    logic                  end_of_grant;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_arbiter (
        .req        (req),
        .last_grant (last_grant_reg),
        .found      (arb_found),
        .winner     (arb_winner)
    );

    // View of the currently granted requester
    assign grant_req  = req[grant_reg];
    assign grant_last = req_last[grant_reg];
    assign grant_data = req_data[int'(grant_reg)*DATA_WIDTH +: DATA_WIDTH];

    // A byte is handed over when the serializer is free and the owner still has one
    assign issue_fire   = (state_reg == UART_ARB_ISSUE) && !tx_busy && grant_req;
    assign wdog_expired = (wdog_reg == WDOG_LIMIT);
    assign end_of_grant = last_flag_reg || (burst_cnt_reg == BURST_LIMIT) || !grant_req;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= UART_ARB_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a completion in the expiry cycle still counts as success
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            UART_ARB_IDLE: begin
                if (arb_found) begin
                    state_next = UART_ARB_ISSUE;
                end
            end
            UART_ARB_ISSUE: begin
                if (!tx_busy) begin
                    state_next = grant_req ? UART_ARB_WAIT_DONE : UART_ARB_RELEASE;
                end
            end
            UART_ARB_WAIT_DONE: begin
                if (tx_done) begin
                    state_next = end_of_grant ? UART_ARB_RELEASE : UART_ARB_ISSUE;
                end else if (wdog_expired) begin
                    state_next = UART_ARB_RELEASE;
                end
            end
            UART_ARB_RELEASE: begin
                state_next = UART_ARB_IDLE;
            end
            default: begin
                state_next = UART_ARB_IDLE;
            end
        endcase
    end

    // Output decode: start pulse and the owner's ack share the issue cycle
    always_comb begin
        tx_start = 1'b0;
        ack      = '0;
        if (issue_fire) begin
            tx_start       = 1'b1;
            ack[grant_reg] = 1'b1;
        end
    end

    // Grant ownership: capture the winner, remember it on release for rotation
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_reg      <= '0;
            last_grant_reg <= LAST_INIT;
        end else begin
            if (state_reg == UART_ARB_IDLE && arb_found) begin
                grant_reg <= arb_winner;
            end
            if (state_reg == UART_ARB_RELEASE) begin
                last_grant_reg <= grant_reg;
            end
        end
    end

    // Byte transfer: latch data and packet-end flag, count bytes in this grant
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_reg   <= '0;
            last_flag_reg <= 1'b0;
            burst_cnt_reg <= '0;
        end else begin
            if (state_reg == UART_ARB_IDLE && arb_found) begin
                burst_cnt_reg <= '0;
            end else if (issue_fire) begin
                tx_data_reg   <= grant_data;
                last_flag_reg <= grant_last;
                burst_cnt_reg <= burst_cnt_reg + 1'b1;
            end
        end
    end

    // Watchdog: restart on each issue, count while waiting, flag a stuck serializer
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_reg        <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (issue_fire) begin
                wdog_reg <= '0;
            end else if (state_reg == UART_ARB_WAIT_DONE) begin
                wdog_reg <= wdog_reg + 1'b1;
                if (!tx_done && wdog_expired) begin
                    timeout_err_reg <= 1'b1;
                end
            end
        end
    end

    assign tx_data     = tx_data_reg;
    assign grant_id    = grant_reg;
    assign busy        = (state_reg != UART_ARB_IDLE);
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with four requesters, MAX_BURST=4 and
// TIMEOUT_CYCLES=100. Inputs change 1 time unit after posedge, outputs are
// sampled on negedge; a single tick task also plays the requesters and serializer.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int TO = 100;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_last;
    logic [NR-1:0]    ack;
    logic             tx_start;
    logic [DW-1:0]    tx_data;
    logic             tx_busy;
    logic             tx_done;
    logic [1:0]       grant_id;
    logic             busy;
    logic             timeout_err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Requester byte queues: {last, data}
    logic [8:0] qmem [NR][64];
    int         head [NR];
    int         tail [NR];
    logic [NR-1:0] withhold;

    // Serializer model
    int cnt;
    int done_delay;
    bit done_en;

    // Transfer log, one entry per tx_start
    int         n_log = 0;
    int         log_gid  [64];
    logic [3:0] log_ack  [64];
    logic [7:0] log_data [64];
    int         log_cyc  [64];
    int         ack_cnt = 0;
    logic       busy_hist [4096];
    logic       terr_hist [4096];
    logic [3:0] s_ack;
    logic       s_start;

    uart_tx_arbiter #(
        .NUM_REQ(NR),
        .DATA_WIDTH(DW),
        .MAX_BURST(MB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .req_last   (req_last),
        .ack        (ack),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .grant_id   (grant_id),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic drive_req();
        for (int i = 0; i < NR; i++) begin
            logic [8:0] e;
            e = (head[i] < tail[i]) ? qmem[i][head[i]] : 9'h000;
            req[i] = (head[i] < tail[i]) && !withhold[i];
            req_data[i*DW +: DW] = e[7:0];
            req_last[i] = e[8];
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic last);
        qmem[i][tail[i]] = {last, d};
        tail[i] = tail[i] + 1;
        drive_req();
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < NR; i++) s += tail[i] - head[i];
        return s;
    endfunction

    // One clock: sample at negedge, then update requesters/serializer after posedge
    task automatic tick();
        @(negedge clk);
        s_ack   = ack;
        s_start = tx_start;
        if (ack != '0) ack_cnt++;
        if (cyc < 4096) begin
            busy_hist[cyc] = busy;
            terr_hist[cyc] = timeout_err;
        end
        if (tx_start && n_log < 64) begin
            log_gid[n_log] = int'(grant_id);
            log_ack[n_log] = ack;
            log_cyc[n_log] = cyc;
        end
        @(posedge clk);
        #1;
        if (s_start && n_log < 64) begin
            log_data[n_log] = tx_data;
            n_log++;
        end
        cyc++;
        for (int i = 0; i < NR; i++) if (s_ack[i]) head[i] = head[i] + 1;
        tx_done = 1'b0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) tx_done = 1'b1;
        end
        if (s_start && done_en) cnt = done_delay - 1;
        drive_req();
    endtask

    task automatic wait_idle(input int max_cyc, input string name);
        int n = 0;
        while (!(busy == 1'b0 && pending() == 0) && n < max_cyc) begin
            tick();
            n++;
        end
        checks++;
        if (n >= max_cyc) begin
            errors++;
            $display("FAIL %s_idle: not idle after %0d cycles, busy=%0b pending=%0d required idle", name, n, busy, pending());
        end
    endtask

    task automatic wait_start(input int n0, input string name);
        int n = 0;
        while (n_log == n0 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (n_log == n0) begin
            errors++;
            $display("FAIL %s_start: no tx_start within 50 cycles, required one", name);
        end
    endtask

    task automatic test_reset();
        tx_busy = 1'b0; tx_done = 1'b0; withhold = '0;
        cnt = 0; done_en = 1'b1; done_delay = 3;
        for (int i = 0; i < NR; i++) begin head[i] = 0; tail[i] = 0; end
        drive_req();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b required 0", busy); end
        checks++; if (ack !== 4'b0) begin errors++; $display("FAIL reset_ack: got %b required 0000", ack); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %0b required 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h required 00", tx_data); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d required 0", grant_id); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %0b required 0", timeout_err); end
        rst = 1'b0;
        repeat (3) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_req_busy: got %0b required 0", busy); end
        $display("test_reset done: errors=%0d", errors);
    endtask

    task automatic test_round_robin();
        int n0 = n_log;
        int a0 = ack_cnt;
        done_delay = 3;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NR; i++) push(i, 8'(16 * i + r), 1'b1);
        wait_idle(400, "rr");
        checks++; if (n_log - n0 !== 8) begin errors++; $display("FAIL rr_count: got %0d starts required 8", n_log - n0); end
        checks++; if (ack_cnt - a0 !== 8) begin errors++; $display("FAIL rr_ack_cycles: got %0d required 8", ack_cnt - a0); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (log_gid[n0+k] !== k % 4) begin errors++; $display("FAIL rr_gid[%0d]: got %0d required %0d", k, log_gid[n0+k], k % 4); end
            checks++;
            if (log_ack[n0+k] !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rr_ack[%0d]: got %b required %b", k, log_ack[n0+k], 4'(1 << (k % 4))); end
            checks++;
            if (log_data[n0+k] !== 8'(16 * (k % 4) + k / 4)) begin errors++; $display("FAIL rr_data[%0d]: got %h required %h", k, log_data[n0+k], 8'(16 * (k % 4) + k / 4)); end
            $display("rr xfer %0d: gid=%0d data=%h", k, log_gid[n0+k], log_data[n0+k]);
        end
    endtask

    task automatic test_single_byte();
        int n0 = n_log;
        int t;
        done_delay = 20;
        push(2, 8'hA5, 1'b1);
        wait_idle(200, "single");
        t = log_cyc[n0] + 20;
        checks++; if (n_log - n0 !== 1) begin errors++; $display("FAIL single_count: got %0d required 1", n_log - n0); end
        checks++; if (log_ack[n0] !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b required 0100", log_ack[n0]); end
        checks++; if (log_gid[n0] !== 2) begin errors++; $display("FAIL single_gid: got %0d required 2", log_gid[n0]); end
        checks++; if (log_data[n0] !== 8'hA5) begin errors++; $display("FAIL single_data: got %h required a5", log_data[n0]); end
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_data_held: got %h required a5", tx_data); end
        checks++; if (busy_hist[t+1] !== 1'b1) begin errors++; $display("FAIL single_busy_release: got %0b required 1", busy_hist[t+1]); end
        checks++; if (busy_hist[t+2] !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %0b required 0", busy_hist[t+2]); end
        $display("single xfer: gid=%0d data=%h start_cyc=%0d", log_gid[n0], log_data[n0], log_cyc[n0]);
    endtask

    task automatic test_busy_hold();
        int n0 = n_log;
        int k;
        done_delay = 3;
        tx_busy = 1'b1;
        push(0, 8'h3C, 1'b1);
        k = cyc;
        repeat (6) tick();
        checks++; if (n_log !== n0) begin errors++; $display("FAIL hold_no_start: got %0d starts required 0 while busy", n_log - n0); end
        tx_busy = 1'b0;
        wait_idle(100, "hold");
        checks++; if (log_cyc[n0] !== k + 6) begin errors++; $display("FAIL hold_start_cyc: got %0d required %0d", log_cyc[n0], k + 6); end
        checks++; if (log_data[n0] !== 8'h3C) begin errors++; $display("FAIL hold_data: got %h required 3c", log_data[n0]); end
        checks++; if (log_gid[n0] !== 0) begin errors++; $display("FAIL hold_gid: got %0d required 0", log_gid[n0]); end
        $display("busy hold xfer: gid=%0d data=%h start_cyc=%0d", log_gid[n0], log_data[n0], log_cyc[n0]);
    endtask

    task automatic test_packet_lock();
        int n0 = n_log;
        int exp_gid [4] = '{1, 1, 1, 0};
        logic [7:0] exp_data [4] = '{8'h10, 8'h11, 8'h12, 8'h55};
        done_delay = 4;
        push(1, 8'h10, 1'b0);
        push(1, 8'h11, 1'b0);
        push(1, 8'h12, 1'b1);
        push(0, 8'h55, 1'b1);
        wait_idle(200, "lock");
        checks++; if (n_log - n0 !== 4) begin errors++; $display("FAIL lock_count: got %0d required 4", n_log - n0); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (log_gid[n0+k] !== exp_gid[k] || log_data[n0+k] !== exp_data[k]) begin
                errors++;
                $display("FAIL lock_xfer[%0d]: got gid=%0d data=%h required gid=%0d data=%h", k, log_gid[n0+k], log_data[n0+k], exp_gid[k], exp_data[k]);
            end
            $display("lock xfer %0d: gid=%0d data=%h", k, log_gid[n0+k], log_data[n0+k]);
        end
        checks++;
        if (log_cyc[n0+1] - log_cyc[n0] !== 5) begin errors++; $display("FAIL lock_b2b_gap: got %0d cycles required 5", log_cyc[n0+1] - log_cyc[n0]); end
    endtask

    task automatic test_burst_cap();
        int n0 = n_log;
        int exp_gid [11] = '{3, 3, 3, 3, 0, 3, 3, 3, 3, 3, 3};
        logic [7:0] exp_data [11] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h77, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        done_delay = 3;
        for (int j = 0; j < 10; j++) push(3, 8'(8'h30 + j), 1'b0);
        push(0, 8'h77, 1'b1);
        wait_idle(400, "burst");
        checks++; if (n_log - n0 !== 11) begin errors++; $display("FAIL burst_count: got %0d required 11", n_log - n0); end
        for (int k = 0; k < 11; k++) begin
            checks++;
            if (log_gid[n0+k] !== exp_gid[k] || log_data[n0+k] !== exp_data[k]) begin
                errors++;
                $display("FAIL burst_xfer[%0d]: got gid=%0d data=%h required gid=%0d data=%h", k, log_gid[n0+k], log_data[n0+k], exp_gid[k], exp_data[k]);
            end
            $display("burst xfer %0d: gid=%0d data=%h", k, log_gid[n0+k], log_data[n0+k]);
        end
    endtask

    task automatic test_withdraw();
        int n0 = n_log;
        int a0 = ack_cnt;
        tx_busy = 1'b1;
        push(1, 8'hEE, 1'b1);
        repeat (3) tick();
        checks++; if (grant_id !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL withdraw_granted: got gid=%0d busy=%0b required gid=1 busy=1", grant_id, busy); end
        withhold[1] = 1'b1;
        drive_req();
        tx_busy = 1'b0;
        tick();
        head[1] = tail[1];
        withhold = '0;
        drive_req();
        wait_idle(20, "withdraw");
        checks++; if (n_log !== n0) begin errors++; $display("FAIL withdraw_no_start: got %0d starts required 0", n_log - n0); end
        checks++; if (ack_cnt !== a0) begin errors++; $display("FAIL withdraw_no_ack: got %0d ack cycles required 0", ack_cnt - a0); end
        checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL withdraw_gid: got %0d required 1", grant_id); end
        $display("withdraw: starts=%0d busy=%0b", n_log - n0, busy);
    endtask

    task automatic test_timeout();
        int n0 = n_log;
        int s;
        done_delay = 3;
        done_en = 1'b0;
        push(2, 8'hC1, 1'b1);
        push(3, 8'hD2, 1'b1);
        wait_start(n0, "timeout");
        done_en = 1'b1;
        s = log_cyc[n0];
        wait_idle(400, "timeout");
        checks++; if (log_gid[n0] !== 2) begin errors++; $display("FAIL to_first_gid: got %0d required 2", log_gid[n0]); end
        checks++; if (terr_hist[s+100] !== 1'b0) begin errors++; $display("FAIL to_early: got %0b required 0 at start+100", terr_hist[s+100]); end
        checks++; if (terr_hist[s+101] !== 1'b1) begin errors++; $display("FAIL to_set: got %0b required 1 at start+101", terr_hist[s+101]); end
        checks++; if (log_gid[n0+1] !== 3 || log_data[n0+1] !== 8'hD2) begin errors++; $display("FAIL to_next: got gid=%0d data=%h required gid=3 data=d2", log_gid[n0+1], log_data[n0+1]); end
        checks++; if (log_cyc[n0+1] !== s + 103) begin errors++; $display("FAIL to_next_cyc: got %0d required %0d", log_cyc[n0+1], s + 103); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %0b required 1", timeout_err); end
        $display("timeout: first gid=%0d next gid=%0d timeout_err=%0b", log_gid[n0], log_gid[n0+1], timeout_err);
    endtask

    task automatic test_reset_mid();
        int n0 = n_log;
        bit any_busy;
        done_delay = 50;
        push(1, 8'h99, 1'b1);
        wait_start(n0, "rstmid");
        repeat (10) tick();
        rst = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %0b required 0", busy); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rstmid_timeout_err: got %0b required 0", timeout_err); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rstmid_gid: got %0d required 0", grant_id); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_tx_data: got %h required 00", tx_data); end
        checks++; if (ack !== 4'b0 || tx_start !== 1'b0) begin errors++; $display("FAIL rstmid_pulses: got ack=%b start=%0b required 0", ack, tx_start); end
        rst = 1'b0;
        any_busy = 1'b0;
        repeat (60) begin
            tick();
            if (busy) any_busy = 1'b1;
        end
        checks++; if (any_busy !== 1'b0) begin errors++; $display("FAIL rstmid_stray_done: got busy=1 required 0 after late tx_done"); end
        n0 = n_log;
        done_delay = 3;
        push(2, 8'h5A, 1'b1);
        push(0, 8'hA0, 1'b1);
        wait_idle(100, "rstmid");
        checks++; if (log_gid[n0] !== 0 || log_gid[n0+1] !== 2) begin errors++; $display("FAIL rstmid_priority: got %0d,%0d required 0,2", log_gid[n0], log_gid[n0+1]); end
        $display("reset mid-transfer: post-reset grants %0d,%0d", log_gid[n0], log_gid[n0+1]);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "global timeout");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_single_byte();
        test_busy_hold();
        test_packet_lock();
        test_burst_cap();
        test_withdraw();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
